// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64-style bus arbiter.
// Imported by the arbiter and its lead counter.
package c64_bus_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        BA_WAIT = 2'd1,
        STEAL   = 2'd2
    } bus_state_t;

    localparam logic PHASE_VID = 1'b0;
    localparam logic PHASE_CPU = 1'b1;

    localparam int LEAD_W = 3;

endpackage

// File: rtl/ba_lead_counter.sv
// Loadable down-counter timing the gap between BA and AEC falling.
// Saturates at zero; last flags a count of one.
module ba_lead_counter
    import c64_bus_pkg::*;
#(
    parameter logic [LEAD_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LEAD_W-1:0] load_val,
    input  logic              dec,
    output logic [LEAD_W-1:0] count,
    output logic              zero,
    output logic              last
);

    assign zero = (count == '0);
    assign last = (count == LEAD_W'(1));

    // Load takes priority; decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= INIT;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - LEAD_W'(1);
        end
    end

endmodule

// File: rtl/c64_bus_arbiter.sv
// Interleaves the 6502 core and the video fetch unit on one bus.
// Even slots go to video, odd slots to the CPU unless video steals.
module c64_bus_arbiter
    import c64_bus_pkg::*;
#(
    parameter int BA_LEAD = 3,
    parameter int AW      = 16,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_ab,
    input  logic [DW-1:0] cpu_do,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_di,
    output logic          cpu_ce,
    input  logic [AW-1:0] vid_addr,
    input  logic          vid_steal,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          ba,
    output logic          aec,
    output logic          phase,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [LEAD_W-1:0] LEAD = LEAD_W'(BA_LEAD);

    bus_state_t        state;
    bus_state_t        state_n;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              cnt_last;
    logic [LEAD_W-1:0] cnt_val;
    logic              cpu_slot;
    logic              grant;
    logic              cpu_rd;
    logic [DW-1:0]     cpu_di_q;

    ba_lead_counter #(
        .INIT (LEAD)
    ) u_lead (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LEAD),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // BA drops as soon as a steal is pending; AEC only once it is active.
    assign ba  = (state == NORMAL);
    assign aec = (state != STEAL);

    // Every CPU-phase slot in BA_WAIT counts, granted or not.
    assign cnt_dec = (state == BA_WAIT) && (phase == PHASE_CPU);

    // CPU owns odd slots except during a steal; BA_WAIT admits writes only.
    assign cpu_slot = (phase == PHASE_CPU) && (state != STEAL);
    assign grant    = cpu_slot && ((state == NORMAL) || cpu_we);
    assign cpu_rd   = grant && !cpu_we;

    // Slot phase and arbitration state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= PHASE_VID;
            state <= NORMAL;
        end else begin
            phase <= ~phase;
            state <= state_n;
        end
    end

    // Next-state logic: steal entry, lead-in countdown and release.
    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        unique case (state)
            NORMAL: begin
                if (phase == PHASE_VID && vid_steal) begin
                    cnt_load = 1'b1;
                    state_n  = (LEAD == '0) ? STEAL : BA_WAIT;
                end
            end
            BA_WAIT: begin
                if (!vid_steal) begin
                    state_n = NORMAL;
                end else if (cnt_zero || (cnt_dec && cnt_last)) begin
                    state_n = STEAL;
                end
            end
            STEAL: begin
                if (phase == PHASE_CPU && !vid_steal) begin
                    state_n = NORMAL;
                end
            end
            default: begin
                state_n = NORMAL;
            end
        endcase
    end

    // Bus mux: a video slot, a granted CPU slot, or an idle CPU slot.
    always_comb begin
        mem_addr  = cpu_ab;
        mem_wdata = cpu_do;
        mem_we    = 1'b0;
        cpu_ce    = 1'b0;
        unique case (1'b1)
            !cpu_slot: begin
                mem_addr = vid_addr;
            end
            grant: begin
                mem_we = cpu_we;
                cpu_ce = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Reads pass straight through; otherwise the CPU sees the last value.
    assign cpu_di = cpu_rd ? mem_rdata : cpu_di_q;

    // Capture bus data at the end of every granted CPU slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_di_q <= '0;
        end else if (grant) begin
            cpu_di_q <= mem_rdata;
        end
    end

    // Register video fetch data with a one-cycle valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_data  <= '0;
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= !cpu_slot;
            if (!cpu_slot) begin
                vid_data <= mem_rdata;
            end
        end
    end

endmodule
